// File: rtl/bounce_box_gen.sv
// Pixel-colour stage for the 640x480 VGA path: draws a bouncing box over a
// dark-blue background with a 1-pixel white border, one move per frame.
module bounce_box_gen #(
  parameter int unsigned H_ACT = 640,
  parameter int unsigned V_ACT = 480,
  parameter int unsigned BOX_W = 32,
  parameter int unsigned BOX_H = 32,
  parameter int unsigned STEP  = 2
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_px_clk,
  input  logic       i_haddr_enb,
  input  logic [9:0] i_hidx,
  input  logic       i_vaddr_enb,
  input  logic [8:0] i_vidx,
  input  logic       i_pause,
  output logic [3:0] o_vga_red,
  output logic [3:0] o_vga_green,
  output logic [3:0] o_vga_blue,
  output logic       o_frame_tick,
  output logic [7:0] o_bounce_cnt
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned XI = 11;
  localparam int unsigned YI = 10;

  localparam logic [XI-1:0] X_MAX  = XI'(H_ACT - BOX_W);
  localparam logic [YI-1:0] Y_MAX  = YI'(V_ACT - BOX_H);
  localparam logic [XI-1:0] X_STEP = XI'(STEP);
  localparam logic [YI-1:0] Y_STEP = YI'(STEP);
  localparam logic [XI-1:0] X_SIZE = XI'(BOX_W);
  localparam logic [YI-1:0] Y_SIZE = YI'(BOX_H);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

  // Direction encoding: 0 = RIGHT/DOWN, 1 = LEFT/UP
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;
  localparam logic [11:0] RGB_BG    = 12'h003;

  logic [XW-1:0] r_box_x;
  logic [YW-1:0] r_box_y;
  logic          r_dir_x;
  logic          r_dir_y;
  logic [2:0]    r_col_idx;
  logic [7:0]    r_bounce_cnt;
  logic          r_vact_d;
  logic          r_frame_tick;
  logic [11:0]   r_rgb;

  logic [XI-1:0] w_x_ext;
  logic [YI-1:0] w_y_ext;
  logic [XI-1:0] w_nx;
  logic [YI-1:0] w_ny;
  logic          w_ndx;
  logic          w_ndy;
  logic          w_bx;
  logic          w_by;
  logic          w_eof;
  logic          w_in_box;
  logic          w_border;
  logic [11:0]   w_pal;
  logic [11:0]   w_rgb;

  assign w_x_ext = {1'b0, r_box_x};
  assign w_y_ext = {1'b0, r_box_y};
  assign w_eof   = i_px_clk & r_vact_d & ~i_vaddr_enb;

  // Next position/direction for both axes; saturating at the walls
  always_comb begin
    w_nx  = w_x_ext;
    w_ndx = r_dir_x;
    w_bx  = 1'b0;
    w_ny  = w_y_ext;
    w_ndy = r_dir_y;
    w_by  = 1'b0;
    if (r_dir_x == DIR_POS) begin
      if (w_x_ext + X_STEP >= X_MAX) begin
        w_nx  = X_MAX;
        w_ndx = DIR_NEG;
        w_bx  = 1'b1;
      end else begin
        w_nx = w_x_ext + X_STEP;
      end
    end else begin
      if (w_x_ext <= X_STEP) begin
        w_nx  = '0;
        w_ndx = DIR_POS;
        w_bx  = 1'b1;
      end else begin
        w_nx = w_x_ext - X_STEP;
      end
    end
    if (r_dir_y == DIR_POS) begin
      if (w_y_ext + Y_STEP >= Y_MAX) begin
        w_ny  = Y_MAX;
        w_ndy = DIR_NEG;
        w_by  = 1'b1;
      end else begin
        w_ny = w_y_ext + Y_STEP;
      end
    end else begin
      if (w_y_ext <= Y_STEP) begin
        w_ny  = '0;
        w_ndy = DIR_POS;
        w_by  = 1'b1;
      end else begin
        w_ny = w_y_ext - Y_STEP;
      end
    end
  end

  // Palette lookup
  always_comb begin
    w_pal = RGB_BLACK;
    case (r_col_idx)
      3'd0: w_pal = 12'hF00;
      3'd1: w_pal = 12'h0F0;
      3'd2: w_pal = 12'h00F;
      3'd3: w_pal = 12'hFF0;
      3'd4: w_pal = 12'h0FF;
      3'd5: w_pal = 12'hF0F;
      3'd6: w_pal = 12'hFFF;
      3'd7: w_pal = 12'hF80;
      default: w_pal = RGB_BLACK;
    endcase
  end

  // Pixel classification: box wins over border
  always_comb begin
    w_in_box = ({1'b0, i_hidx} >= w_x_ext) && ({1'b0, i_hidx} < w_x_ext + X_SIZE) &&
               ({1'b0, i_vidx} >= w_y_ext) && ({1'b0, i_vidx} < w_y_ext + Y_SIZE);
    w_border = (i_hidx == '0) || (i_hidx == X_LAST) ||
               (i_vidx == '0) || (i_vidx == Y_LAST);
    w_rgb    = RGB_BG;
    if (!(i_haddr_enb && i_vaddr_enb)) begin
      w_rgb = RGB_BLACK;
    end else if (w_in_box) begin
      w_rgb = w_pal;
    end else if (w_border) begin
      w_rgb = RGB_WHITE;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_box_x      <= '0;
      r_box_y      <= '0;
      r_dir_x      <= DIR_POS;
      r_dir_y      <= DIR_POS;
      r_col_idx    <= '0;
      r_bounce_cnt <= '0;
      r_vact_d     <= 1'b0;
      r_frame_tick <= 1'b0;
      r_rgb        <= RGB_BLACK;
    end else begin
      r_frame_tick <= w_eof;
      if (i_px_clk) begin
        r_vact_d <= i_vaddr_enb;
        r_rgb    <= w_rgb;
        if (w_eof && !i_pause) begin
          r_box_x <= w_nx[XW-1:0];
          r_box_y <= w_ny[YW-1:0];
          r_dir_x <= w_ndx;
          r_dir_y <= w_ndy;
          // A corner hit counts once
          if (w_bx || w_by) begin
            r_col_idx    <= r_col_idx + 3'd1;
            r_bounce_cnt <= r_bounce_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign o_vga_red    = r_rgb[11:8];
  assign o_vga_green  = r_rgb[7:4];
  assign o_vga_blue   = r_rgb[3:0];
  assign o_frame_tick = r_frame_tick;
  assign o_bounce_cnt = r_bounce_cnt;

endmodule

// File: tb/tb_bounce_box_gen.sv
// Randomized scoreboard bench for bounce_box_gen against a frame-level model.
module tb_bounce_box_gen;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int BW    = 32;
  localparam int BH    = 32;
  localparam int STEP  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       px = 1'b0;
  logic       hen = 1'b0;
  logic [9:0] hidx = '0;
  logic       ven = 1'b0;
  logic [8:0] vidx = '0;
  logic       pause = 1'b0;
  logic [3:0] red, green, blue;
  logic       tick;
  logic [7:0] bcnt;

  bounce_box_gen dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_px_clk     (px),
    .i_haddr_enb  (hen),
    .i_hidx       (hidx),
    .i_vaddr_enb  (ven),
    .i_vidx       (vidx),
    .i_pause      (pause),
    .o_vga_red    (red),
    .o_vga_green  (green),
    .o_vga_blue   (blue),
    .o_frame_tick (tick),
    .o_bounce_cnt (bcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] rgb;
    logic        tick;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;
  int n_corner = 0;

  // Reference model: box position, direction as +1/-1, colour, bounce count
  int m_x, m_y, m_dx, m_dy, m_col, m_cnt;
  bit m_vact;
  logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                           12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_col = 0; m_cnt = 0; m_vact = 0;
  endtask

  function automatic logic [11:0] exp_rgb(input bit he, input bit ve, input int h, input int v);
    if (!(he && ve)) return 12'h000;
    if (h >= m_x && h < m_x + BW && v >= m_y && v < m_y + BH) return pal[m_col];
    if (h == 0 || h == H_ACT - 1 || v == 0 || v == V_ACT - 1) return 12'hFFF;
    return 12'h003;
  endfunction

  // One axis move: returns new position, flips direction on wall contact
  task automatic move_axis(inout int pos, inout int dir, input int lim, output bit hit);
    int np;
    np  = pos + dir * STEP;
    hit = 0;
    if (np >= lim) begin pos = lim; dir = -1; hit = 1; end
    else if (np <= 0) begin pos = 0; dir = 1; hit = 1; end
    else pos = np;
  endtask

  task automatic strobe(input bit he, input int h, input bit ve, input int v, input bit ps);
    exp_t e;
    bit eof, hx, hy;
    e.rgb = exp_rgb(he, ve, h, v);
    eof = m_vact && !ve;
    m_vact = ve;
    if (eof && !ps) begin
      move_axis(m_x, m_dx, H_ACT - BW, hx);
      move_axis(m_y, m_dy, V_ACT - BH, hy);
      if (hx || hy) begin
        m_col = (m_col + 1) % 8;
        m_cnt = (m_cnt + 1) % 256;
      end
      if (hx && hy) n_corner++;
    end
    e.tick = eof;
    e.cnt  = 8'(m_cnt);
    q.push_back(e);
    hen = he; hidx = 10'(h); ven = ve; vidx = 9'(v); pause = ps; px = 1'b1;
    @(negedge clk);
    px = 1'b0;
    if ($urandom % 4 == 0) @(negedge clk);
    @(negedge clk);
  endtask

  function automatic int rnd(input int n);
    return int'($urandom % n);
  endfunction

  task automatic frame(input bit full, input bit ps);
    if (full) begin
      strobe(1, 0, 1, 0, 1'($urandom));
      strobe(1, m_x + rnd(BW), 1, m_y + rnd(BH), 1'($urandom));
      strobe(1, H_ACT - 1, 1, m_y + rnd(BH), 1'($urandom));
      strobe(1, (m_x > 0) ? m_x - 1 : m_x + BW, 1, m_y, 1'($urandom));
      strobe(1, m_x + BW - 1, 1, m_y + BH - 1, 1'($urandom));
      strobe(1, rnd(H_ACT), 1, V_ACT - 1, 1'($urandom));
      strobe(1, rnd(H_ACT), 1, rnd(V_ACT), 1'($urandom));
      strobe(0, m_x + rnd(BW), 1, m_y + rnd(BH), 1'($urandom));
    end else begin
      strobe(1, rnd(H_ACT), 1, rnd(V_ACT), 1'($urandom));
    end
    strobe(1'($urandom), rnd(H_ACT), 0, rnd(V_ACT), ps);
    if ($urandom % 8 == 0) strobe(1'($urandom), rnd(H_ACT), 0, rnd(V_ACT), 1'($urandom));
  endtask

  // Monitor: pops one expectation per strobe, checks hold between strobes
  logic [11:0] prev_rgb = '0;
  logic [7:0]  prev_cnt = '0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      n_chk++;
      if ({red, green, blue} != 12'h000 || tick !== 1'b0 || bcnt != 8'd0) begin
        n_err++;
        $display("FAIL reset_zero: rgb=%h tick=%b cnt=%0d, required 000/0/0", {red, green, blue}, tick, bcnt);
      end
      prev_rgb = '0;
      prev_cnt = '0;
    end else if (px) begin
      n_chk++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL no_expect: strobe with empty scoreboard at %0t", $time);
      end else begin
        e = q.pop_front();
        if ({red, green, blue} !== e.rgb) begin
          n_err++;
          $display("FAIL pixel_rgb: got %h, required %h (h=%0d v=%0d hen=%b ven=%b) at %0t",
                   {red, green, blue}, e.rgb, hidx, vidx, hen, ven, $time);
        end
        n_chk++;
        if (tick !== e.tick || bcnt !== e.cnt) begin
          n_err++;
          $display("FAIL tick_cnt: tick=%b cnt=%0d, required tick=%b cnt=%0d at %0t",
                   tick, bcnt, e.tick, e.cnt, $time);
        end
      end
      prev_rgb = {red, green, blue};
      prev_cnt = bcnt;
    end else begin
      n_chk++;
      if ({red, green, blue} !== prev_rgb || tick !== 1'b0 || bcnt !== prev_cnt) begin
        n_err++;
        $display("FAIL hold: rgb=%h tick=%b cnt=%0d, required rgb=%h tick=0 cnt=%0d at %0t",
                 {red, green, blue}, tick, bcnt, prev_rgb, prev_cnt, $time);
      end
    end
  end

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(1, 0);
    frame(1, 0);
    // Reset in the middle of an active frame
    strobe(1, 10, 1, 10, 0);
    strobe(1, 20, 1, 10, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    strobe(1, 300, 0, 200, 0);
    strobe(1, 0, 1, 0, 0);
    strobe(1, 5, 1, 5, 0);
    strobe(1, 100, 1, 100, 0);
    strobe(1, 1, 1, 1, 0);
    strobe(0, 5, 1, 5, 0);
    strobe(1, 50, 0, 50, 0);
    frame(1, 0);
    // Three paused frame ends
    for (int i = 0; i < 3; i++) frame(1, 1);
    // Long unpaused run covers wall and corner bounces
    for (int i = 0; i < 4300; i++) begin
      frame((i % 64 == 0) || m_x >= H_ACT - BW - 10 || m_x <= 8 ||
            m_y >= V_ACT - BH - 10 || m_y <= 8, 0);
    end
    for (int i = 0; i < 120; i++) frame(i % 4 == 0, 1'($urandom % 3 == 0));
    repeat (4) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("corner bounces seen by model: %0d", n_corner);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
